// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and picks the next PC from a fixed-priority
// set of sources. Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic [1:0]       branch_cond,
    input  logic             zero,
    input  logic             negative,
    input  logic [WIDTH-1:0] branch_address,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_address,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_address,
    input  logic             link,
    input  logic             ret,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             redirect,
    output logic             ras_empty,
    output logic             ras_overflow
);

    localparam int unsigned      PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [WIDTH-1:0] ALIGN_MSK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] EXC_VEC_W = WIDTH'(EXC_VECTOR);

    typedef enum logic [3:0] {
        SRC_SEQ,
        SRC_EXC,
        SRC_HOLD,
        SRC_ERET,
        SRC_RET,
        SRC_JR,
        SRC_JUMP,
        SRC_BRANCH
    } pc_src_t;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_redirect;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_ret_target;
    logic             w_cond;
    logic             w_redirect_next;
    pc_src_t          w_src;

    assign w_pc_plus4 = r_pc + WIDTH'(4);

    always_comb begin
        w_cond = 1'b0;
        case (branch_cond)
            2'b00:   w_cond = zero;
            2'b01:   w_cond = ~zero;
            2'b10:   w_cond = negative;
            default: w_cond = ~negative;
        endcase
    end

    // Exception beats stall so a trap is never lost behind a pipeline hold.
    always_comb begin
        w_src     = SRC_SEQ;
        w_next_pc = w_pc_plus4;
        if (exception) begin
            w_src     = SRC_EXC;
            w_next_pc = EXC_VEC_W & ALIGN_MSK;
        end else if (stall) begin
            w_src     = SRC_HOLD;
            w_next_pc = r_pc;
        end else if (eret) begin
            w_src     = SRC_ERET;
            w_next_pc = r_epc & ALIGN_MSK;
        end else if (ret) begin
            w_src     = SRC_RET;
            w_next_pc = w_ret_target & ALIGN_MSK;
        end else if (jr) begin
            w_src     = SRC_JR;
            w_next_pc = jr_address & ALIGN_MSK;
        end else if (jump) begin
            w_src     = SRC_JUMP;
            w_next_pc = jump_address & ALIGN_MSK;
        end else if (branch && w_cond) begin
            w_src     = SRC_BRANCH;
            w_next_pc = branch_address & ALIGN_MSK;
        end
    end

    assign w_redirect_next = (w_src != SRC_SEQ) && (w_src != SRC_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_redirect <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_redirect <= w_redirect_next;
            if (w_src == SRC_EXC) begin
                r_epc <= r_pc;
            end
        end
    end

`ifdef PC_RAS_EN
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;
    logic [CNT_W-1:0] r_ras_count;
    logic             r_ras_overflow;

    logic [PTR_W-1:0] w_top_idx;
    logic             w_ras_active;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

    // r_ras_ptr is the next free slot; the top of stack sits one below it.
    assign w_top_idx    = r_ras_ptr - PTR_W'(1);
    assign w_ras_active = ~stall & ~exception;
    assign w_full       = (r_ras_count == CNT_W'(RAS_DEPTH));
    assign w_push       = w_ras_active & link;
    assign w_pop        = w_ras_active & ret & ~eret & (r_ras_count != '0);
    assign w_ret_target = (r_ras_count != '0) ? r_ras[w_top_idx] : jr_address;

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_push && w_pop) begin
                r_ras[w_top_idx] <= w_pc_plus4;
            end else if (w_push) begin
                r_ras[r_ras_ptr] <= w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ras_ptr      <= '0;
            r_ras_count    <= '0;
            r_ras_overflow <= 1'b0;
        end else if (w_push && !w_pop) begin
            r_ras_ptr <= r_ras_ptr + PTR_W'(1);
            if (w_full) begin
                r_ras_overflow <= 1'b1;
            end else begin
                r_ras_count <= r_ras_count + CNT_W'(1);
            end
        end else if (w_pop && !w_push) begin
            r_ras_ptr   <= w_top_idx;
            r_ras_count <= r_ras_count - CNT_W'(1);
        end
    end

    assign ras_empty    = (r_ras_count == '0);
    assign ras_overflow = r_ras_overflow;
`else
    logic w_unused_ras;

    assign w_ret_target = jr_address;
    assign ras_empty    = 1'b1;
    assign ras_overflow = 1'b0;
    assign w_unused_ras = link ^ (CNT_W'(RAS_DEPTH) == '0);
`endif

    assign pc_out   = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign epc      = r_epc;
    assign redirect = r_redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, branches, exception/eret, priority, wrap and the RAS
// (RAS scenarios only when PC_RAS_EN is defined).
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_1000;
    localparam logic [31:0] EV = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        reset, stall, branch, zero, negative, jump, jr, link, ret, exception, eret;
    logic [1:0]  branch_cond;
    logic [31:0] branch_address, jump_address, jr_address;
    logic [31:0] pc_out, pc_plus4, epc;
    logic        redirect, ras_empty, ras_overflow;

    logic [15:0] pc16, pc16_p4, epc16;
    logic        redir16, empty16, ovf16;
    logic [15:0] z16 = '0;
    logic        z1  = 1'b0;
    logic [1:0]  z2  = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret [4] = '{32'h44, 32'h34, 32'h24, 32'h14};

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_cond(branch_cond),
        .zero(zero), .negative(negative), .branch_address(branch_address), .jump(jump),
        .jump_address(jump_address), .jr(jr), .jr_address(jr_address), .link(link), .ret(ret),
        .exception(exception), .eret(eret), .pc_out(pc_out), .pc_plus4(pc_plus4), .epc(epc),
        .redirect(redirect), .ras_empty(ras_empty), .ras_overflow(ras_overflow)
    );

    pc_unit #(.WIDTH(16), .RESET_VECTOR(16'hFFF8), .EXC_VECTOR(EV), .RAS_DEPTH(4)) u_dut16 (
        .clk(clk), .reset(reset), .stall(z1), .branch(z1), .branch_cond(z2),
        .zero(z1), .negative(z1), .branch_address(z16), .jump(z1),
        .jump_address(z16), .jr(z1), .jr_address(z16), .link(z1), .ret(z1),
        .exception(z1), .eret(z1), .pc_out(pc16), .pc_plus4(pc16_p4), .epc(epc16),
        .redirect(redir16), .ras_empty(empty16), .ras_overflow(ovf16)
    );

    task automatic idle();
        stall = 0; branch = 0; branch_cond = 2'b00; zero = 0; negative = 0;
        jump = 0; jr = 0; link = 0; ret = 0; exception = 0; eret = 0;
        branch_address = '0; jump_address = '0; jr_address = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        checks++; if (pc_out !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, RV); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", epc); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", redirect); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty got %b exp 1", ras_empty); end
        checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL reset_ras_ovf got %b exp 0", ras_overflow); end
        checks++; if (pc16 !== 16'hFFF8) begin errors++; $display("FAIL reset_pc16 got %h exp fff8", pc16); end
        reset = 0;
        #1;
        checks++; if (pc_plus4 !== RV + 32'd4) begin errors++; $display("FAIL pc_plus4 got %h exp %h", pc_plus4, RV + 32'd4); end
        step();
        checks++; if (pc_out !== RV + 32'd4) begin errors++; $display("FAIL seq1_pc got %h exp %h", pc_out, RV + 32'd4); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq1_redirect got %b exp 0", redirect); end
        checks++; if (pc16 !== 16'hFFFC) begin errors++; $display("FAIL seq1_pc16 got %h exp fffc", pc16); end
        checks++; if (pc16_p4 !== 16'h0000) begin errors++; $display("FAIL wrap_p4_16 got %h exp 0000", pc16_p4); end
        step();
        checks++; if (pc_out !== RV + 32'd8) begin errors++; $display("FAIL seq2_pc got %h exp %h", pc_out, RV + 32'd8); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq2_redirect got %b exp 0", redirect); end
        checks++; if (pc16 !== 16'h0000) begin errors++; $display("FAIL wrap_pc16 got %h exp 0000", pc16); end
    endtask

    task automatic test_branch();
        idle(); jump = 1; jump_address = 32'h200; step(); idle();
        checks++; if (pc_out !== 32'h200 || redirect !== 1'b1) begin errors++; $display("FAIL jump pc %h red %b exp 200 1", pc_out, redirect); end
        branch = 1; branch_cond = 2'b01; zero = 0; branch_address = 32'h103; step();
        checks++; if (pc_out !== 32'h100 || redirect !== 1'b1) begin errors++; $display("FAIL bne_taken pc %h red %b exp 100 1", pc_out, redirect); end
        zero = 1; step();
        checks++; if (pc_out !== 32'h104 || redirect !== 1'b0) begin errors++; $display("FAIL bne_not pc %h red %b exp 104 0", pc_out, redirect); end
        branch_cond = 2'b00; zero = 1; branch_address = 32'h208; step();
        checks++; if (pc_out !== 32'h208) begin errors++; $display("FAIL beq_taken pc %h exp 208", pc_out); end
        branch_cond = 2'b10; zero = 0; negative = 1; branch_address = 32'h30C; step();
        checks++; if (pc_out !== 32'h30C) begin errors++; $display("FAIL blt_taken pc %h exp 30c", pc_out); end
        branch_cond = 2'b11; negative = 1; branch_address = 32'h400; step();
        checks++; if (pc_out !== 32'h310 || redirect !== 1'b0) begin errors++; $display("FAIL bge_not pc %h red %b exp 310 0", pc_out, redirect); end
        idle();
    endtask

    task automatic test_exception();
        idle(); jump = 1; jump_address = 32'h40; step(); idle();
        stall = 1; step();
        checks++; if (pc_out !== 32'h40 || redirect !== 1'b0) begin errors++; $display("FAIL stall pc %h red %b exp 40 0", pc_out, redirect); end
        exception = 1; step();
        checks++; if (pc_out !== EV || epc !== 32'h40) begin errors++; $display("FAIL exc pc %h epc %h exp %h 40", pc_out, epc, EV); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL exc_redirect got %b exp 1", redirect); end
        idle(); eret = 1; step();
        checks++; if (pc_out !== 32'h40 || redirect !== 1'b1) begin errors++; $display("FAIL eret pc %h red %b exp 40 1", pc_out, redirect); end
        idle();
    endtask

    task automatic test_priority();
        idle(); jr = 1; jr_address = 32'h303; jump = 1; jump_address = 32'h400;
        branch = 1; branch_cond = 2'b00; zero = 1; branch_address = 32'h500; step();
        checks++; if (pc_out !== 32'h300) begin errors++; $display("FAIL jr_over_jump pc %h exp 300", pc_out); end
        jr = 0; step();
        checks++; if (pc_out !== 32'h400) begin errors++; $display("FAIL jump_over_branch pc %h exp 400", pc_out); end
        eret = 1; jr = 1; step();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL eret_over_jr pc %h exp 40", pc_out); end
        idle(); jump = 1; jump_address = 32'hFFFF_FFFC; step(); idle();
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4 got %h exp 0", pc_plus4); end
        step();
        checks++; if (pc_out !== 32'h0 || redirect !== 1'b0) begin errors++; $display("FAIL wrap pc %h red %b exp 0 0", pc_out, redirect); end
    endtask

    task automatic test_reset_mid();
        idle(); jump = 1; jump_address = 32'h700; reset = 1; step(); reset = 0; idle();
        checks++; if (pc_out !== RV || redirect !== 1'b0) begin errors++; $display("FAIL reset_mid pc %h red %b exp %h 0", pc_out, redirect, RV); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        idle(); reset = 1; step(); reset = 0;
        jump = 1; jump_address = 32'h0; step();
        for (int i = 0; i < 5; i++) begin
            idle(); link = 1; jump = 1;
            jump_address = (i == 4) ? 32'h80 : 32'((i + 1) * 16);
            step();
        end
        idle();
        checks++; if (ras_overflow !== 1'b1 || ras_empty !== 1'b0) begin errors++; $display("FAIL ras_push ovf %b empty %b exp 1 0", ras_overflow, ras_empty); end
        checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL ras_push_pc got %h exp 80", pc_out); end
        for (int i = 0; i < 4; i++) begin
            ret = 1; jr_address = 32'h600; step();
            checks++; if (pc_out !== exp_ret[i]) begin errors++; $display("FAIL ras_pop%0d got %h exp %h", i, pc_out, exp_ret[i]); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_drained got %b exp 1", ras_empty); end
        step();
        checks++; if (pc_out !== 32'h600 || ras_overflow !== 1'b1) begin errors++; $display("FAIL ras_empty_ret pc %h ovf %b exp 600 1", pc_out, ras_overflow); end
        idle(); jump = 1; jump_address = 32'h20; step();
        link = 1; jump_address = 32'h80; step(); idle();
        link = 1; ret = 1; step(); idle();
        checks++; if (pc_out !== 32'h24 || ras_empty !== 1'b0) begin errors++; $display("FAIL link_ret pc %h empty %b exp 24 0", pc_out, ras_empty); end
        ret = 1; step(); idle();
        checks++; if (pc_out !== 32'h84 || ras_empty !== 1'b1) begin errors++; $display("FAIL link_ret_top pc %h empty %b exp 84 1", pc_out, ras_empty); end
        stall = 1; link = 1; jump = 1; jump_address = 32'h90; step();
        checks++; if (pc_out !== 32'h84 || ras_empty !== 1'b1) begin errors++; $display("FAIL stall_link pc %h empty %b exp 84 1", pc_out, ras_empty); end
        exception = 1; step();
        checks++; if (pc_out !== EV || ras_empty !== 1'b1) begin errors++; $display("FAIL exc_link pc %h empty %b exp %h 1", pc_out, ras_empty, EV); end
        idle(); link = 1; jump = 1; jump_address = 32'hA0; step();
        reset = 1; step(); reset = 0; idle();
        checks++; if (ras_empty !== 1'b1 || ras_overflow !== 1'b0) begin errors++; $display("FAIL ras_reset empty %b ovf %b exp 1 0", ras_empty, ras_overflow); end
    endtask
`else
    task automatic test_ret_as_jr();
        idle(); ret = 1; link = 1; jr_address = 32'h502; step(); idle();
        checks++; if (pc_out !== 32'h500 || redirect !== 1'b1) begin errors++; $display("FAIL ret_jr pc %h red %b exp 500 1", pc_out, redirect); end
        checks++; if (ras_empty !== 1'b1 || ras_overflow !== 1'b0) begin errors++; $display("FAIL no_ras empty %b ovf %b exp 1 0", ras_empty, ras_overflow); end
    endtask
`endif

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_branch();
        test_exception();
        test_priority();
        test_reset_mid();
`ifdef PC_RAS_EN
        test_ras();
`else
        test_ret_as_jr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS core. It holds the fetch address and selects the next PC from sequential, conditional-branch, jump, jump-register, exception and exception-return sources under a fixed priority. It adds stall support, a configurable reset vector, an exception PC (EPC) register and an optional return-address stack (RAS). It sits between the control/ALU stage and instruction fetch, and drives the instruction-memory address.

## Interface
- WIDTH, 32, PC and target width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0180, PC loaded on exception (truncated to WIDTH)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥ 2; used only with PC_RAS_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC, EPC and RAS unchanged
- branch  in  1  conditional branch instruction
- branch_cond  in  2  00 EQ (zero), 01 NE (!zero), 10 LT (negative), 11 GE (!negative)
- zero  in  1  ALU zero flag
- negative  in  1  ALU sign flag
- branch_address  in  WIDTH  branch target
- jump  in  1  unconditional jump
- jump_address  in  WIDTH  jump target
- jr  in  1  jump-register
- jr_address  in  WIDTH  register target
- link  in  1  call; push pc_plus4 onto RAS
- ret  in  1  return; target from RAS
- exception  in  1  trap request
- eret  in  1  return from exception
- pc_out  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc_out + 4 (combinational)
- epc  out  WIDTH  saved exception PC (registered)
- redirect  out  1  registered; 1 when the last update was non-sequential
- ras_empty  out  1  RAS holds no entries
- ras_overflow  out  1  sticky; a push overwrote a live entry

## Operation
- Next-PC priority, evaluated each clk:
  1. reset
  2. exception
  3. stall
  4. eret
  5. ret
  6. jr
  7. jump
  8. taken branch
  9. pc_plus4
- Taken branch: branch = 1 and the condition selected by branch_cond holds.
- exception: pc_out ← EXC_VECTOR and epc ← pc_out, even when stall = 1; RAS is untouched.
- eret: pc_out ← epc.
- Targets: bits [1:0] of every target are forced to 0 before loading.
- pc_plus4 wraps modulo 2^WIDTH, so all-ones minus 3 rolls over to 0.
- redirect ← 1 on any update from sources 2 or 4–8; it is 0 on sequential updates and on reset. During stall, redirect ← 0.
- RAS is a circular stack with a pointer and a count (0..RAS_DEPTH). It only operates on non-stalled cycles without exception.
  - link: push pc_plus4. When count = RAS_DEPTH, the oldest entry is overwritten, count stays, and ras_overflow ← 1.
  - ret, count > 0: target = top of stack; pop.
  - ret, count = 0: target = jr_address; count stays 0.
  - link and ret together: pop first (target = old top), then push pc_plus4 into the freed slot; count unchanged.
- A link combined with jump/jr still pushes.

## Timing
- Single-cycle update: the selected target appears on pc_out one clk after the inputs are sampled.
- Reset values:
  - pc_out = RESET_VECTOR
  - epc = 0
  - redirect = 0
  - RAS count = 0, ras_empty = 1
  - ras_overflow = 0
- Reset mid-operation discards RAS contents and any pending redirect on the same edge.
- Stall: all registers hold, except when exception = 1.
- pc_plus4 and ras_empty are combinational from the registered state.

## Configuration
- PC_RAS_EN defined: the RAS is built as described above.
- PC_RAS_EN undefined:
  - no RAS storage
  - ret behaves exactly as jr (target jr_address)
  - link is ignored
  - ras_empty is tied to 1 and ras_overflow to 0

## Test plan
- Reset then 3 free-running cycles: pc_out = RESET_VECTOR, +4, +8; redirect = 0 throughout.
- branch = 1, branch_cond = 01, zero = 0, branch_address = 0x103 → next pc_out = 0x100, redirect = 1. Repeat with zero = 1 → pc_plus4.
- exception while stall = 1 at pc_out = 0x40 → pc_out = EXC_VECTOR, epc = 0x40. Then eret → pc_out = 0x40.
- With PC_RAS_EN, RAS_DEPTH = 4:
  - five link pushes at PCs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_overflow = 1.
  - Four ret → targets 0x44, 0x34, 0x24, 0x14, then ras_empty = 1.
  - A fifth ret → jr_address.
- Simultaneous link + ret with top = 0x24 at pc_out = 0x80 → pc_out = 0x24, new top = 0x84, count unchanged.
- WIDTH = 16, pc_out = 0xFFFC → next pc_out = 0x0000.
